// File: rtl/node_ibuffer_flit_recv.sv
// node_ibuffer_flit_recv: packs a header + 32-bit data flit stream into 128-bit instruction-buffer line writes, then acks the sender
// Ports: clk/rst_n (async active-low reset)
//   recv_valid/recv_flit/recv_ready : incoming NoC flits (header then data words)
//   mem_cen/mem_wen/mem_ready/mem_addr/mem_wdata/mem_strb : line write port
//   send_valid/send_flit/send_ready : acknowledge flit {2'b10, 17'd0, count}
//   busy : not idle, load_done : ack accepted pulse, hdr_err : bad header dropped pulse
module node_ibuffer_flit_recv #(
  parameter int DATA_WIDTH = 128,
  parameter int MEM_AW     = 15,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int FLIT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  recv_valid,
  input  logic [FLIT_WIDTH-1:0] recv_flit,
  output logic                  recv_ready,
  output logic                  mem_cen,
  output logic                  mem_wen,
  input  logic                  mem_ready,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [STRB_WIDTH-1:0] mem_strb,
  output logic                  send_valid,
  output logic [FLIT_WIDTH-1:0] send_flit,
  input  logic                  send_ready,
  output logic                  busy,
  output logic                  load_done,
  output logic                  hdr_err
);
  typedef enum logic [1:0] {IDLE, DATA, WRITE, ACK} state_t;
  state_t                  state_q, state_d;
  logic                    rdy_q, load_done_q, hdr_err_q;
  logic [16:0]             addr_q;
  logic [12:0]             rem_q, cnt_q;
  logic [DATA_WIDTH-1:0]   line_q;
  logic [STRB_WIDTH-1:0]   strb_q;
  logic [MEM_AW-1:0]       line_addr_q;
  logic [1:0]              lane;
  logic                    take, bad;
  assign lane = addr_q[1:0];
  assign take = recv_valid & rdy_q;
  assign bad  = recv_flit[31:30] != 2'b01;
  always_comb
    state_d = state_q == IDLE  ? (take ? (bad ? IDLE : (recv_flit[12:0] == 13'd0 ? ACK : DATA)) : IDLE) :
              state_q == DATA  ? (take && (lane == 2'd3 || rem_q == 13'd1) ? WRITE : DATA) :
              state_q == WRITE ? (mem_ready ? (rem_q == 13'd0 ? ACK : DATA) : WRITE) :
                                 (send_ready ? IDLE : ACK);
  // recv_ready is registered from the next state so it is low during reset and never depends on recv_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rdy_q       <= 1'b0;
      load_done_q <= 1'b0;
      hdr_err_q   <= 1'b0;
      addr_q      <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      line_q      <= '0;
      strb_q      <= '0;
      line_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= state_d == IDLE || state_d == DATA;
      load_done_q <= state_q == ACK && send_ready;
      hdr_err_q   <= state_q == IDLE && take && bad;
      if (state_q == IDLE && take && !bad) begin
        addr_q <= recv_flit[29:13];
        rem_q  <= recv_flit[12:0];
        cnt_q  <= '0;
        line_q <= '0;
        strb_q <= '0;
      end
      if (state_q == DATA && take) begin
        line_q[lane*FLIT_WIDTH +: FLIT_WIDTH] <= recv_flit;
        strb_q[lane*(FLIT_WIDTH/8) +: FLIT_WIDTH/8] <= '1;
        line_addr_q <= addr_q[MEM_AW+1:2];
        addr_q      <= addr_q + 17'd1;
        rem_q       <= rem_q - 13'd1;
        cnt_q       <= cnt_q + 13'd1;
      end
      if (state_q == WRITE && mem_ready) begin
        line_q <= '0;
        strb_q <= '0;
      end
    end
  end
  assign recv_ready = rdy_q;
  assign mem_cen    = state_q == WRITE;
  assign mem_wen    = state_q == WRITE;
  assign mem_addr   = line_addr_q;
  assign mem_wdata  = line_q;
  assign mem_strb   = strb_q;
  assign send_valid = state_q == ACK;
  assign send_flit  = state_q == ACK ? {2'b10, 17'd0, cnt_q} : '0;
  assign busy       = state_q != IDLE;
  assign load_done  = load_done_q;
  assign hdr_err    = hdr_err_q;
endmodule

// File: tb/tb_node_ibuffer_flit_recv.sv
// tb_node_ibuffer_flit_recv: table vectors, hand corner sequences and random loads checked against a line-packing model
module tb_node_ibuffer_flit_recv;
  logic clk = 0, rst_n = 0, recv_valid = 0, mem_ready = 1, send_ready = 1;
  logic [31:0] recv_flit = 0;
  logic recv_ready, mem_cen, mem_wen, send_valid, busy, load_done, hdr_err;
  logic [14:0] mem_addr;
  logic [127:0] mem_wdata;
  logic [15:0] mem_strb;
  logic [31:0] send_flit;
  node_ibuffer_flit_recv dut (
    .clk(clk), .rst_n(rst_n), .recv_valid(recv_valid), .recv_flit(recv_flit), .recv_ready(recv_ready),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_strb(mem_strb), .send_valid(send_valid), .send_flit(send_flit),
    .send_ready(send_ready), .busy(busy), .load_done(load_done), .hdr_err(hdr_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [14:0]  a;
    logic [127:0] d;
    logic [15:0]  s;
  } wr_t;
  typedef struct {
    logic [31:0]         hdr;
    int                  n;
    logic [7:0][31:0]    w;
    int                  nw;
    logic [1:0][14:0]    ea;
    logic [1:0][15:0]    es;
    logic [1:0][127:0]   ed;
    logic [31:0]         ack;
  } vec_t;
  wr_t got_q[$], exp_q[$];
  logic [31:0] ack_q[$];
  int checks = 0, fails = 0, cyc = 0, acc_cyc = 0, ack_cyc = 0, ld_cnt = 0, he_cnt = 0, stall_left = 0;
  int t_hdr = 0, t_last = 0;
  bit rnd_mr = 0, rnd_sr = 0, sr_val = 1, acc = 0, ack_prev = 0, stall_prev = 0;
  logic sv, mc, mw, rr, bz, ld, he;
  logic [31:0] sf;
  logic [14:0] ma, h_a;
  logic [127:0] md, h_d;
  logic [15:0] ms, h_s;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
    checks++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask
  // one clock: sample outputs at negedge, record transfers, then drive ready inputs after the posedge
  task automatic tick();
    @(negedge clk);
    cyc++;
    sv = send_valid; sf = send_flit; mc = mem_cen; mw = mem_wen; rr = recv_ready; bz = busy;
    ld = load_done; he = hdr_err; ma = mem_addr; md = mem_wdata; ms = mem_strb;
    acc = recv_valid && recv_ready;
    if (acc) acc_cyc = cyc;
    if (rst_n) begin
      chk("wen_eq_cen", mw, mc);
      chk("load_done_timing", ld, ack_prev);
      if (stall_prev && mc) begin
        chk("hold_addr", ma, h_a);
        chk("hold_data", md, h_d);
        chk("hold_strb", ms, h_s);
      end
      if (stall_left > 0 && mc) begin
        chk("stall_recv_ready", rr, 0);
        stall_left--;
      end
      if (mc && mem_ready) got_q.push_back('{ma, md, ms});
      if (sv && send_ready) begin ack_q.push_back(sf); ack_cyc = cyc; end
      if (ld) ld_cnt++;
      if (he) he_cnt++;
      ack_prev = sv && send_ready;
      stall_prev = mc && !mem_ready;
      h_a = ma; h_d = md; h_s = ms;
    end else begin
      ack_prev = 0;
      stall_prev = 0;
    end
    @(posedge clk);
    #1;
    mem_ready = stall_left > 0 ? 1'b0 : (rnd_mr ? 1'($urandom % 2) : 1'b1);
    send_ready = rnd_sr ? 1'($urandom % 2) : sr_val;
  endtask
  task automatic put(input logic [31:0] f);
    int t = 0;
    recv_valid = 1;
    recv_flit = f;
    tick();
    while (!acc && t < 100) begin tick(); t++; end
    chk("flit_accept", acc, 1);
    recv_valid = 0;
    recv_flit = $urandom;
  endtask
  task automatic run_load(input logic [31:0] hdr, input logic [31:0] w[16], input int n, input bit gaps);
    int t = 0;
    got_q.delete(); ack_q.delete(); ld_cnt = 0; he_cnt = 0;
    put(hdr);
    t_hdr = acc_cyc;
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom % 3) tick();
      put(w[i]);
    end
    t_last = acc_cyc;
    while (ld_cnt == 0 && t < 400) begin tick(); t++; end
    chk("load_done_seen", ld_cnt, 1);
  endtask
  // reference: each word goes to (addr+i) mod 2^17; a line closes at lane 3 or on the last word
  task automatic model(input logic [31:0] hdr, input logic [31:0] w[16], input int n);
    int a, lane;
    wr_t e;
    exp_q.delete();
    e.d = 0; e.s = 0; e.a = 0;
    for (int i = 0; i < n; i++) begin
      a = (int'(hdr[29:13]) + i) % 131072;
      lane = a % 4;
      e.d[lane*32 +: 32] = w[i];
      e.s[lane*4 +: 4] = 4'hF;
      e.a = 15'((a / 4) % 32768);
      if (lane == 3 || i == n - 1) begin
        exp_q.push_back(e);
        e.d = 0; e.s = 0;
      end
    end
  endtask
  task automatic cmp_model(input string tag, input int n);
    chk({tag, "_nwr"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk({tag, "_addr"}, got_q[i].a, exp_q[i].a);
      chk({tag, "_data"}, got_q[i].d, exp_q[i].d);
      chk({tag, "_strb"}, got_q[i].s, exp_q[i].s);
    end
    chk({tag, "_nack"}, ack_q.size(), 1);
    if (ack_q.size() > 0) chk({tag, "_ack"}, ack_q[0], 32'h8000_0000 + n);
    chk({tag, "_no_hdr_err"}, he_cnt, 0);
  endtask
  task automatic check_rst(input string tag);
    chk({tag, "_recv_ready"}, rr, 0);
    chk({tag, "_mem_cen"}, mc, 0);
    chk({tag, "_mem_wen"}, mw, 0);
    chk({tag, "_mem_addr"}, ma, 0);
    chk({tag, "_mem_wdata"}, md, 0);
    chk({tag, "_mem_strb"}, ms, 0);
    chk({tag, "_send_valid"}, sv, 0);
    chk({tag, "_send_flit"}, sf, 0);
    chk({tag, "_busy"}, bz, 0);
    chk({tag, "_load_done"}, ld, 0);
    chk({tag, "_hdr_err"}, he, 0);
  endtask
  initial begin
    vec_t tv[4];
    logic [31:0] w[16];
    logic [31:0] hdr;
    int n, a, t;
    tv[0] = '{32'h4000_8004, 4, '0, 1, '0, '0, '0, 32'h8000_0004};
    tv[0].w[3:0] = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
    tv[0].ea[0] = 15'd1; tv[0].es[0] = 16'hFFFF;
    tv[0].ed[0] = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
    tv[1] = '{32'h4000_C003, 3, '0, 2, '0, '0, '0, 32'h8000_0003};
    tv[1].w[2:0] = {32'h5A5A_0003, 32'h5959_0002, 32'h5858_0001};
    tv[1].ea[0] = 15'd1; tv[1].es[0] = 16'hFF00; tv[1].ed[0] = {32'h5959_0002, 32'h5858_0001, 64'h0};
    tv[1].ea[1] = 15'd2; tv[1].es[1] = 16'h000F; tv[1].ed[1] = {96'h0, 32'h5A5A_0003};
    tv[2] = '{32'h4000_0000, 0, '0, 0, '0, '0, '0, 32'h8000_0000};
    tv[3] = '{32'h7FFF_C004, 4, '0, 2, '0, '0, '0, 32'h8000_0004};
    tv[3].w[3:0] = {32'h7777_0003, 32'h7777_0002, 32'h7777_0001, 32'h7777_0000};
    tv[3].ea[0] = 15'h7FFF; tv[3].es[0] = 16'hFF00; tv[3].ed[0] = {32'h7777_0001, 32'h7777_0000, 64'h0};
    tv[3].ea[1] = 15'h0000; tv[3].es[1] = 16'h00FF; tv[3].ed[1] = {64'h0, 32'h7777_0003, 32'h7777_0002};
    repeat (2) tick();
    check_rst("reset");
    rst_n = 1;
    repeat (2) tick();
    chk("idle_recv_ready", rr, 1);
    chk("idle_busy", bz, 0);
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 16; i++) w[i] = i < 8 ? tv[v].w[i] : 32'h0;
      run_load(tv[v].hdr, w, tv[v].n, 0);
      chk("vec_nwr", got_q.size(), tv[v].nw);
      for (int i = 0; i < tv[v].nw && i < got_q.size(); i++) begin
        chk("vec_addr", got_q[i].a, tv[v].ea[i]);
        chk("vec_strb", got_q[i].s, tv[v].es[i]);
        chk("vec_data", got_q[i].d, tv[v].ed[i]);
      end
      chk("vec_nack", ack_q.size(), 1);
      if (ack_q.size() > 0) chk("vec_ack", ack_q[0], tv[v].ack);
    end
    // num=0: ack valid in the cycle right after the header, held while send_ready is low
    got_q.delete(); ack_q.delete(); ld_cnt = 0;
    sr_val = 0;
    put(32'h4000_0000);
    tick();
    chk("num0_send_valid", sv, 1);
    chk("num0_send_flit", sf, 32'h8000_0000);
    chk("num0_no_mem", mc, 0);
    sr_val = 1;
    tick();
    chk("num0_send_held", sv, 1);
    t = 0;
    while (ld_cnt == 0 && t < 20) begin tick(); t++; end
    chk("num0_load_done", ld_cnt, 1);
    chk("num0_nack", ack_q.size(), 1);
    chk("num0_nwr", got_q.size(), 0);
    // back-to-back aligned 8-word load: 4 words per 5 cycles
    for (int i = 0; i < 16; i++) w[i] = 32'h1000_0000 + i;
    run_load(32'h4000_0008, w, 8, 0);
    chk("thru_last_word", t_last - t_hdr, 9);
    chk("thru_ack", ack_cyc - t_hdr, 11);
    model(32'h4000_0008, w, 8);
    cmp_model("thru", 8);
    // 5-cycle memory stall on the first line while more data is offered
    stall_left = 5;
    mem_ready = 0;
    for (int i = 0; i < 16; i++) w[i] = 32'h2000_0000 + i * 3;
    run_load(32'h4000_2008, w, 8, 0);
    chk("stall_used", stall_left, 0);
    model(32'h4000_2008, w, 8);
    cmp_model("stall", 8);
    // bad header is dropped with one hdr_err pulse, then a good load still works
    he_cnt = 0;
    put(32'hC000_0001);
    tick();
    chk("bad_hdr_err", he, 1);
    chk("bad_busy", bz, 0);
    tick();
    chk("bad_hdr_err_once", he, 0);
    chk("bad_busy2", bz, 0);
    chk("bad_pulses", he_cnt, 1);
    for (int i = 0; i < 16; i++) w[i] = 32'h3000_0000 + i;
    run_load(32'h4000_8004, w, 4, 0);
    model(32'h4000_8004, w, 4);
    cmp_model("after_bad", 4);
    // reset after the second data word of a 4-word load
    got_q.delete(); ack_q.delete(); ld_cnt = 0;
    put(32'h4000_8004);
    put(32'hEEEE_0001);
    put(32'hEEEE_0002);
    rst_n = 0;
    tick();
    check_rst("midrst");
    tick();
    rst_n = 1;
    repeat (3) tick();
    chk("midrst_no_write", got_q.size(), 0);
    chk("midrst_no_ack", ack_q.size(), 0);
    chk("midrst_no_done", ld_cnt, 0);
    chk("midrst_idle_ready", rr, 1);
    for (int i = 0; i < 16; i++) w[i] = 32'h4400_0000 + i;
    run_load(32'h4000_8004, w, 4, 0);
    model(32'h4000_8004, w, 4);
    cmp_model("post_rst", 4);
    // random loads with random gaps and back-pressure
    rnd_mr = 1;
    rnd_sr = 1;
    for (int r = 0; r < 24; r++) begin
      n = $urandom_range(0, 12);
      a = (r % 4 == 0) ? 131072 - $urandom_range(1, 6) : $urandom_range(0, 131071);
      hdr = {2'b01, 17'(a), 13'(n)};
      for (int i = 0; i < 16; i++) w[i] = $urandom;
      run_load(hdr, w, n, 1);
      model(hdr, w, n);
      cmp_model("rnd", n);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
